// File: rtl/conv_sched_pkg.sv
// Shared types and derived-constant helpers for the convolution spike scheduler.
package conv_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SPK,
    ACCUM,
    DRAIN,
    ACTIV,
    ACTIV_WAIT,
    STEP_END
  } sched_state_e;

  // Taps per event (KK) and output-channel groups (OC_GROUPS) for a given geometry.
  function automatic int kk_of(input int k);
    return k * k;
  endfunction

  function automatic int oc_groups_of(input int out_channels, input int ec_size);
    return out_channels / ec_size;
  endfunction

endpackage

// File: rtl/conv_spk_sched_if.sv
// Input spike event stream: valid/ready handshake carrying x, y, channel and end-of-timestep.
interface conv_spk_sched_if #(
  parameter int XW  = 5,
  parameter int ICW = 3
);
  logic           spk_valid;
  logic           spk_ready;
  logic [XW-1:0]  spk_x;
  logic [XW-1:0]  spk_y;
  logic [ICW-1:0] spk_ic;
  logic           spk_eot;

  modport master (output spk_valid, spk_x, spk_y, spk_ic, spk_eot, input spk_ready);
  modport slave  (input spk_valid, spk_x, spk_y, spk_ic, spk_eot, output spk_ready);
endinterface

// File: rtl/conv_tap_gen.sv
// Kernel tap walker: turns one latched event into K*K affected-neuron coordinates,
// flagging coordinates that fall outside the output frame. Outputs are registered.
module conv_tap_gen
  import conv_sched_pkg::*;
#(
  parameter int KERNEL_SIZE        = 3,
  parameter int INPUT_FRAME_WIDTH  = 28,
  parameter int OUTPUT_FRAME_WIDTH = 26
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 load,
  input  logic                                 step,
  input  logic                                 drain,
  input  logic [$clog2(INPUT_FRAME_WIDTH)-1:0] spk_x,
  input  logic [$clog2(INPUT_FRAME_WIDTH)-1:0] spk_y,
  output logic [$clog2(KERNEL_SIZE)+1:0]       filter_phase,
  output logic [$clog2(INPUT_FRAME_WIDTH)-1:0] addr_y,
  output logic [$clog2(INPUT_FRAME_WIDTH)-1:0] addr_x,
  output logic                                 invalid,
  output logic                                 tap_last
);

  localparam int AW  = $clog2(INPUT_FRAME_WIDTH);
  localparam int KW  = $clog2(KERNEL_SIZE) + 1;
  localparam int FPW = $clog2(KERNEL_SIZE) + 2;
  localparam int KK  = kk_of(KERNEL_SIZE);

  logic [KW-1:0] kx_q, ky_q, kx_d, ky_d;
  logic [AW-1:0] x_q, y_q, x_src, y_src;
  logic [AW:0]   ox_g, oy_g;
  logic          inv_d;

  always_comb begin
    kx_d = kx_q;
    ky_d = ky_q;
    if (load) begin
      kx_d = '0;
      ky_d = '0;
    end else if (step) begin
      if (kx_q == KW'(KERNEL_SIZE - 1)) begin
        kx_d = '0;
        ky_d = ky_q + 1'b1;
      end else begin
        kx_d = kx_q + 1'b1;
      end
    end
    // On the accept cycle the event is not yet latched, so read it straight from the bus.
    x_src = load ? spk_x : x_q;
    y_src = load ? spk_y : y_q;
    ox_g  = {1'b0, x_src} - (AW+1)'(kx_d);
    oy_g  = {1'b0, y_src} - (AW+1)'(ky_d);
    inv_d = ox_g[AW] | oy_g[AW]
          | (ox_g[AW-1:0] >= AW'(OUTPUT_FRAME_WIDTH))
          | (oy_g[AW-1:0] >= AW'(OUTPUT_FRAME_WIDTH));
  end

  assign tap_last = (filter_phase == FPW'(KK - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kx_q         <= '0;
      ky_q         <= '0;
      filter_phase <= '0;
      addr_y       <= '0;
      addr_x       <= '0;
      invalid      <= 1'b0;
    end else begin
      kx_q <= kx_d;
      ky_q <= ky_d;
      if (load || step) begin
        filter_phase <= load ? '0 : filter_phase + 1'b1;
        addr_y       <= oy_g[AW-1:0];
        addr_x       <= ox_g[AW-1:0];
        invalid      <= inv_d;
      end else begin
        invalid <= drain;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      x_q <= spk_x;
      y_q <= spk_y;
    end
  end

endmodule

// File: rtl/conv_spk_sched.sv
// Timestep scheduler for the conv_nc core array: expands spike events into kernel taps,
// then runs one activation sweep per output-channel group and advances the timestep.
module conv_spk_sched
  import conv_sched_pkg::*;
#(
  parameter int IN_CHANNELS        = 2,
  parameter int OUT_CHANNELS       = 4,
  parameter int EC_SIZE            = 2,
  parameter int KERNEL_SIZE        = 3,
  parameter int INPUT_FRAME_WIDTH  = 28,
  parameter int OUTPUT_FRAME_WIDTH = 26,
  parameter int NUM_STEPS          = 25,
  parameter int ACTIV_CYCLES       = OUTPUT_FRAME_WIDTH * OUTPUT_FRAME_WIDTH + 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  conv_spk_sched_if.slave                      spk,
  output logic                                 en_accum,
  output logic                                 en_activ,
  output logic [$clog2(IN_CHANNELS)+1:0]       ic,
  output logic [$clog2(KERNEL_SIZE)+1:0]       filter_phase,
  output logic [$clog2(OUT_CHANNELS)+1:0]      oc_phase,
  output logic [$clog2(INPUT_FRAME_WIDTH)-1:0] affect_neur_addr_y,
  output logic [$clog2(INPUT_FRAME_WIDTH)-1:0] affect_neur_addr_x,
  output logic                                 neur_addr_invalid,
  output logic                                 last_time_step,
  output logic [$clog2(NUM_STEPS):0]           time_step,
  output logic                                 busy,
  output logic                                 done
);

  localparam int ICW       = $clog2(IN_CHANNELS) + 2;
  localparam int OCW       = $clog2(OUT_CHANNELS) + 2;
  localparam int TSW       = $clog2(NUM_STEPS) + 1;
  localparam int CW        = $clog2(ACTIV_CYCLES) + 1;
  localparam int OC_GROUPS = oc_groups_of(OUT_CHANNELS, EC_SIZE);

  sched_state_e   state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [TSW-1:0] ts_d;
  logic [OCW-1:0] oc_d;
  logic [ICW-1:0] ic_d;
  logic           ready_q;
  logic           accept, tap_load, tap_step, tap_last;
  logic           done_d, last_d;

  assign spk.spk_ready = ready_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ts_d     = time_step;
    oc_d     = oc_phase;
    ic_d     = ic;
    tap_load = 1'b0;
    tap_step = 1'b0;
    accept   = ready_q & spk.spk_valid;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WAIT_SPK;
          ts_d    = '0;
          oc_d    = '0;
        end
      end
      WAIT_SPK: begin
        if (accept) begin
          if (spk.spk_eot) begin
            state_d = DRAIN;
          end else if (spk.spk_ic < ICW'(IN_CHANNELS)) begin
            ic_d     = spk.spk_ic;
            tap_load = 1'b1;
            state_d  = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (tap_last) state_d = WAIT_SPK;
        else          tap_step = 1'b1;
      end
      DRAIN: state_d = ACTIV;
      ACTIV: begin
        cnt_d   = CW'(ACTIV_CYCLES - 1);
        state_d = ACTIV_WAIT;
      end
      ACTIV_WAIT: begin
        // The ACTIV cycle is part of the sweep window, so leave one count early.
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CW'(1)) begin
          if (oc_phase < OCW'(OC_GROUPS - 1)) begin
            oc_d    = oc_phase + 1'b1;
            state_d = ACTIV;
          end else begin
            oc_d    = '0;
            state_d = STEP_END;
          end
        end
      end
      STEP_END: begin
        if (time_step == TSW'(NUM_STEPS - 1)) begin
          state_d = IDLE;
        end else begin
          ts_d    = time_step + 1'b1;
          state_d = WAIT_SPK;
        end
      end
      default: state_d = IDLE;
    endcase
    done_d = (state_d == STEP_END) && (time_step == TSW'(NUM_STEPS - 1));
    last_d = (state_d != IDLE) && (ts_d == TSW'(NUM_STEPS - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      time_step      <= '0;
      oc_phase       <= '0;
      ic             <= '0;
      ready_q        <= 1'b0;
      en_accum       <= 1'b0;
      en_activ       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      last_time_step <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      time_step      <= ts_d;
      oc_phase       <= oc_d;
      ic             <= ic_d;
      ready_q        <= (state_d == WAIT_SPK);
      en_accum       <= (state_d == ACCUM);
      en_activ       <= (state_d == ACTIV);
      busy           <= (state_d != IDLE);
      done           <= done_d;
      last_time_step <= last_d;
    end
  end

  conv_tap_gen #(
    .KERNEL_SIZE        (KERNEL_SIZE),
    .INPUT_FRAME_WIDTH  (INPUT_FRAME_WIDTH),
    .OUTPUT_FRAME_WIDTH (OUTPUT_FRAME_WIDTH)
  ) u_tap_gen (
    .clk          (clk),
    .rst          (rst),
    .load         (tap_load),
    .step         (tap_step),
    .drain        (state_d == DRAIN),
    .spk_x        (spk.spk_x),
    .spk_y        (spk.spk_y),
    .filter_phase (filter_phase),
    .addr_y       (affect_neur_addr_y),
    .addr_x       (affect_neur_addr_x),
    .invalid      (neur_addr_invalid),
    .tap_last     (tap_last)
  );

endmodule

// File: tb/tb_conv_spk_sched.sv
// Directed bench for conv_spk_sched: tap walk, frame edges, timestep sequencing,
// back-to-back handshake and asynchronous reset.
module tb_conv_spk_sched;

  localparam int IN_CH  = 2;
  localparam int OUT_CH = 4;
  localparam int EC     = 2;
  localparam int K      = 3;
  localparam int IFW    = 28;
  localparam int OFW    = 26;
  localparam int NSTEPS = 3;
  localparam int XW     = $clog2(IFW);
  localparam int ICW    = $clog2(IN_CH) + 2;
  localparam int FPW    = $clog2(K) + 2;
  localparam int OCW    = $clog2(OUT_CH) + 2;
  localparam int TSW    = $clog2(NSTEPS) + 1;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic           en_accum, en_activ, neur_addr_invalid, last_time_step, busy, done;
  logic [ICW-1:0] ic;
  logic [FPW-1:0] filter_phase;
  logic [OCW-1:0] oc_phase;
  logic [XW-1:0]  addr_y, addr_x;
  logic [TSW-1:0] time_step;

  int total = 0;
  int bad   = 0;

  conv_spk_sched_if #(.XW(XW), .ICW(ICW)) spk_bus ();

  conv_spk_sched #(
    .IN_CHANNELS        (IN_CH),
    .OUT_CHANNELS       (OUT_CH),
    .EC_SIZE            (EC),
    .KERNEL_SIZE        (K),
    .INPUT_FRAME_WIDTH  (IFW),
    .OUTPUT_FRAME_WIDTH (OFW),
    .NUM_STEPS          (NSTEPS)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .spk                (spk_bus),
    .en_accum           (en_accum),
    .en_activ           (en_activ),
    .ic                 (ic),
    .filter_phase       (filter_phase),
    .oc_phase           (oc_phase),
    .affect_neur_addr_y (addr_y),
    .affect_neur_addr_x (addr_x),
    .neur_addr_invalid  (neur_addr_invalid),
    .last_time_step     (last_time_step),
    .time_step          (time_step),
    .busy               (busy),
    .done               (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_evt(input int x, input int y, input int c, input logic eot);
    chk("evt_ready", 32'(spk_bus.spk_ready), 1);
    spk_bus.spk_x     = XW'(x);
    spk_bus.spk_y     = XW'(y);
    spk_bus.spk_ic    = ICW'(c);
    spk_bus.spk_eot   = eot;
    spk_bus.spk_valid = 1'b1;
    @(negedge clk);
    spk_bus.spk_valid = 1'b0;
  endtask

  task automatic check_taps(input int x, input int y, input logic [8:0] mask);
    for (int k = 0; k < 9; k++) begin
      chk("tap_en", 32'(en_accum), 1);
      chk("tap_fp", 32'(filter_phase), k);
      chk("tap_ay", 32'(addr_y), (y - k / 3) & 31);
      chk("tap_ax", 32'(addr_x), (x - k % 3) & 31);
      chk("tap_inv", 32'(neur_addr_invalid), 32'(mask[k]));
      chk("tap_ready", 32'(spk_bus.spk_ready), 0);
      @(negedge clk);
    end
    chk("post_ready", 32'(spk_bus.spk_ready), 1);
    chk("post_en", 32'(en_accum), 0);
  endtask

  task automatic step_end(input int ts);
    int n;
    send_evt(0, 0, 0, 1'b1);
    chk("drain_inv", 32'(neur_addr_invalid), 1);
    chk("drain_en", 32'(en_accum), 0);
    chk("drain_activ", 32'(en_activ), 0);
    @(negedge clk);
    chk("activ0", 32'(en_activ), 1);
    chk("activ0_oc", 32'(oc_phase), 0);
    chk("activ_ts", 32'(time_step), ts);
    chk("activ_last", 32'(last_time_step), (ts == NSTEPS - 1) ? 1 : 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!en_activ && n < 2000);
    chk("activ_gap", n, 678);
    chk("activ1_oc", 32'(oc_phase), 1);
    @(negedge clk);
    chk("activ_pulse", 32'(en_activ), 0);
    repeat (677) @(negedge clk);
    chk("se_oc", 32'(oc_phase), 0);
    chk("se_done", 32'(done), (ts == NSTEPS - 1) ? 1 : 0);
    chk("se_busy", 32'(busy), 1);
    @(negedge clk);
    if (ts == NSTEPS - 1) begin
      chk("fin_busy", 32'(busy), 0);
      chk("fin_done", 32'(done), 0);
      chk("fin_last", 32'(last_time_step), 0);
      chk("fin_ready", 32'(spk_bus.spk_ready), 0);
    end else begin
      chk("next_ts", 32'(time_step), ts + 1);
      chk("next_ready", 32'(spk_bus.spk_ready), 1);
      chk("next_last", 32'(last_time_step), (ts + 1 == NSTEPS - 1) ? 1 : 0);
      chk("next_done", 32'(done), 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_ready"}, 32'(spk_bus.spk_ready), 0);
    chk({tag, "_en"}, 32'(en_accum), 0);
    chk({tag, "_activ"}, 32'(en_activ), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_ts"}, 32'(time_step), 0);
    chk({tag, "_oc"}, 32'(oc_phase), 0);
    chk({tag, "_fp"}, 32'(filter_phase), 0);
    chk({tag, "_ay"}, 32'(addr_y), 0);
    chk({tag, "_ax"}, 32'(addr_x), 0);
    chk({tag, "_inv"}, 32'(neur_addr_invalid), 0);
    chk({tag, "_last"}, 32'(last_time_step), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    spk_bus.spk_valid = 1'b0;
    spk_bus.spk_x     = '0;
    spk_bus.spk_y     = '0;
    spk_bus.spk_ic    = '0;
    spk_bus.spk_eot   = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    rst = 1'b1;
    @(negedge clk);

    // Valid while idle is not accepted
    spk_bus.spk_x = XW'(5);
    spk_bus.spk_y = XW'(5);
    spk_bus.spk_valid = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(spk_bus.spk_ready), 0);
    chk("idle_en", 32'(en_accum), 0);
    chk("idle_busy", 32'(busy), 0);
    spk_bus.spk_valid = 1'b0;

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", 32'(busy), 1);
    chk("start_ready", 32'(spk_bus.spk_ready), 1);
    chk("start_ts", 32'(time_step), 0);
    chk("start_last", 32'(last_time_step), 0);

    // Step 0: interior, corner and far-edge events
    send_evt(5, 5, 0, 1'b0);
    chk("evt_ic0", 32'(ic), 0);
    check_taps(5, 5, 9'h000);
    send_evt(0, 0, 0, 1'b0);
    check_taps(0, 0, 9'h1FE);
    send_evt(27, 27, 0, 1'b0);
    check_taps(27, 27, 9'h0FF);
    step_end(0);

    // Step 1: start while busy is ignored; back-to-back held-valid events
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_start_ts", 32'(time_step), 1);
    chk("busy_start_ready", 32'(spk_bus.spk_ready), 1);
    spk_bus.spk_x     = XW'(10);
    spk_bus.spk_y     = XW'(10);
    spk_bus.spk_ic    = ICW'(1);
    spk_bus.spk_eot   = 1'b0;
    spk_bus.spk_valid = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      chk("b2b_ready", 32'(spk_bus.spk_ready), 0);
      chk("b2b_en", 32'(en_accum), 1);
      chk("b2b_fp", 32'(filter_phase), i - 1);
      chk("b2b_ic", 32'(ic), 1);
    end
    @(negedge clk);
    chk("b2b_ready10", 32'(spk_bus.spk_ready), 1);
    chk("b2b_bubble", 32'(en_accum), 0);
    spk_bus.spk_x  = XW'(7);
    spk_bus.spk_y  = XW'(7);
    spk_bus.spk_ic = ICW'(0);
    @(negedge clk);
    spk_bus.spk_valid = 1'b0;
    check_taps(7, 7, 9'h000);
    step_end(1);

    // Step 2 (last): dropped channel, then empty timestep end
    chk("s2_last", 32'(last_time_step), 1);
    send_evt(3, 3, IN_CH, 1'b0);
    chk("drop_en", 32'(en_accum), 0);
    chk("drop_ready", 32'(spk_bus.spk_ready), 1);
    step_end(2);

    // Asynchronous reset in the middle of a tap walk
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_evt(5, 5, 1, 1'b0);
    repeat (4) @(negedge clk);
    chk("mid_fp", 32'(filter_phase), 4);
    rst = 1'b0;
    #1;
    check_all_zero("arst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rs_ready", 32'(spk_bus.spk_ready), 1);
    send_evt(9, 9, IN_CH, 1'b0);
    chk("rs_drop_en", 32'(en_accum), 0);
    send_evt(1, 1, 1, 1'b0);
    chk("rs_ic", 32'(ic), 1);
    check_taps(1, 1, 9'h1E4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
